// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: fetch port, load/store port and memory bus of the arbiter
interface cpu_mem_arbiter_if;
  logic        ireq_i;
  logic [31:0] iaddr_i;
  logic        igrant_o;
  logic        irvalid_o;
  logic [31:0] irdata_o;
  logic        dreq_i;
  logic [31:0] daddr_i;
  logic        dwe_i;
  logic [3:0]  dwmask_i;
  logic [31:0] dwdata_i;
  logic        dgrant_o;
  logic        drvalid_o;
  logic [31:0] drdata_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  ireq_i, iaddr_i, dreq_i, daddr_i, dwe_i, dwmask_i, dwdata_i, mem_rdata_i,
    output igrant_o, irvalid_o, irdata_o, dgrant_o, drvalid_o, drdata_o,
           mem_en_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o
  );
  modport master (
    output ireq_i, iaddr_i, dreq_i, daddr_i, dwe_i, dwmask_i, dwdata_i, mem_rdata_i,
    input  igrant_o, irvalid_o, irdata_o, dgrant_o, drvalid_o, drdata_o,
           mem_en_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port memory between fetch (I) and load/store (D) ports
module cpu_mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk_i,
  input logic             reset_ni,
  cpu_mem_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]             r_streak;
  logic [3:0]             w_streak_nxt;
  logic                   w_force;
  logic                   w_igrant;
  logic                   w_dgrant;
  logic [MEM_LATENCY-1:0] r_pv;
  logic [MEM_LATENCY-1:0] r_po;
  logic                   r_irvalid;
  logic                   r_drvalid;
  logic [31:0]            r_irdata;
  logic [31:0]            r_drdata;
  logic                   w_tail_i;
  logic                   w_tail_d;
  // D wins unless I has waited through LIMIT D grants; nothing is granted in reset
  always_comb begin
    w_force      = bus.ireq_i && r_streak == LIMIT;
    w_igrant     = reset_ni && (w_force || (bus.ireq_i && !bus.dreq_i));
    w_dgrant     = reset_ni && !w_force && bus.dreq_i;
    w_streak_nxt = (w_igrant || !bus.ireq_i) ? 4'd0 :
                   (w_dgrant && r_streak != LIMIT) ? r_streak + 4'd1 : r_streak;
    w_tail_i     = r_pv[MEM_LATENCY-1] && !r_po[MEM_LATENCY-1];
    w_tail_d     = r_pv[MEM_LATENCY-1] && r_po[MEM_LATENCY-1];
  end
  assign bus.igrant_o    = w_igrant;
  assign bus.dgrant_o    = w_dgrant;
  assign bus.mem_en_o    = w_igrant | w_dgrant;
  assign bus.mem_addr_o  = w_dgrant ? bus.daddr_i : bus.iaddr_i;
  assign bus.mem_we_o    = w_dgrant & bus.dwe_i;
  assign bus.mem_wmask_o = (w_dgrant & bus.dwe_i) ? bus.dwmask_i : 4'd0;
  assign bus.mem_wdata_o = w_dgrant ? bus.dwdata_i : 32'd0;
  assign bus.irvalid_o   = r_irvalid;
  assign bus.irdata_o    = r_irdata;
  assign bus.drvalid_o   = r_drvalid;
  assign bus.drdata_o    = r_drdata;
  // anti-starvation streak of D grants taken while I is waiting
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_streak <= 4'd0;
    else r_streak <= w_streak_nxt;
  end
  // {valid, owner} tracking pipe aligned with the memory read latency; owner 1 = D
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_pv <= '0;
      r_po <= '0;
    end else begin
      r_pv[0] <= (w_igrant | w_dgrant) && !(w_dgrant && bus.dwe_i);
      r_po[0] <= w_dgrant;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_po[i] <= r_po[i-1];
      end
    end
  end
  // register each returning word to its owner; an idle port keeps its last data
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_irvalid <= 1'b0;
      r_drvalid <= 1'b0;
      r_irdata  <= 32'd0;
      r_drdata  <= 32'd0;
    end else begin
      r_irvalid <= w_tail_i;
      r_drvalid <= w_tail_d;
      if (w_tail_i) r_irdata <= bus.mem_rdata_i;
      if (w_tail_d) r_drdata <= bus.mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed checks of grant priority, starvation guard, routing and reset
module tb_cpu_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] qa;
  logic [31:0] qb0, qb1, qb2;
  cpu_mem_arbiter_if bus_a ();
  cpu_mem_arbiter_if bus_b ();
  cpu_mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (.clk_i(clk), .reset_ni(rst_n), .bus(bus_a));
  cpu_mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (.clk_i(clk), .reset_ni(rst_n), .bus(bus_b));
  always #5 clk = ~clk;
  assign bus_a.mem_rdata_i = qa;
  assign bus_b.mem_rdata_i = qb2;
  // 1-cycle byte-masked memory; word w initialises to A5A5_00ww
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (bus_a.mem_en_o) begin
      if (bus_a.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus_a.mem_wmask_o[b]) mem_a[bus_a.mem_addr_o[9:2]][b*8+:8] <= bus_a.mem_wdata_o[b*8+:8];
      end else begin
        qa <= mem_a[bus_a.mem_addr_o[9:2]];
      end
    end
  end
  // 3-cycle read-only memory for the long-latency instance
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (bus_b.mem_en_o && !bus_b.mem_we_o) begin
      qb0 <= mem_b[bus_b.mem_addr_o[9:2]];
    end
    qb1 <= qb0;
    qb2 <= qb1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                       input logic we, input logic [3:0] m, input logic [31:0] wd);
    bus_a.ireq_i   = ir;
    bus_a.iaddr_i  = ia;
    bus_a.dreq_i   = dr;
    bus_a.daddr_i  = da;
    bus_a.dwe_i    = we;
    bus_a.dwmask_i = m;
    bus_a.dwdata_i = wd;
  endtask
  logic        t1_req  [6] = '{1, 1, 1, 0, 0, 0};
  logic [31:0] t1_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0};
  logic        t1_rv   [6] = '{0, 0, 1, 1, 1, 0};
  logic [31:0] t1_rd   [6] = '{0, 0, 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 0};
  logic        t4_ir   [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
  logic        t4_dr   [9] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
  logic [31:0] t4_ad   [9] = '{32'h10, 32'h20, 32'h30, 32'h40, 0, 0, 0, 0, 0};
  logic        t4_irv  [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
  logic        t4_drv  [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
  logic [31:0] t4_rd   [9] = '{0, 0, 0, 0, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C, 32'hA5A5_0010, 0};
  initial begin
    drv_a(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
    bus_b.ireq_i = 0; bus_b.iaddr_i = 0; bus_b.dreq_i = 0; bus_b.daddr_i = 0;
    bus_b.dwe_i = 0; bus_b.dwmask_i = 0; bus_b.dwdata_i = 0;
    @(negedge clk);
    chk("rst igrant", 32'(bus_a.igrant_o), 0);
    chk("rst dgrant", 32'(bus_a.dgrant_o), 0);
    chk("rst irvalid", 32'(bus_a.irvalid_o), 0);
    chk("rst drvalid", 32'(bus_a.drvalid_o), 0);
    chk("rst irdata", bus_a.irdata_o, 0);
    chk("rst streak", 32'(u_a.r_streak), 0);
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    nxt();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus_a.ireq_i  = t1_req[k];
      bus_a.iaddr_i = t1_addr[k];
      @(negedge clk);
      chk($sformatf("t1 igrant c%0d", k), 32'(bus_a.igrant_o), 32'(t1_req[k]));
      chk($sformatf("t1 mem_en c%0d", k), 32'(bus_a.mem_en_o), 32'(t1_req[k]));
      chk($sformatf("t1 mem_addr c%0d", k), bus_a.mem_addr_o, t1_addr[k]);
      chk($sformatf("t1 irvalid c%0d", k), 32'(bus_a.irvalid_o), 32'(t1_rv[k]));
      if (t1_rv[k]) chk($sformatf("t1 irdata c%0d", k), bus_a.irdata_o, t1_rd[k]);
      nxt();
    end
    drv_a(1'b1, 32'h4, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t2 streak c%0d", k), 32'(u_a.r_streak), 32'(k % 5));
      chk($sformatf("t2 igrant c%0d", k), 32'(bus_a.igrant_o), 32'(k % 5 == 4));
      chk($sformatf("t2 dgrant c%0d", k), 32'(bus_a.dgrant_o), 32'(k % 5 != 4));
      chk($sformatf("t2 irvalid c%0d", k), 32'(bus_a.irvalid_o), 32'(k >= 2 && (k - 2) % 5 == 4));
      chk($sformatf("t2 drvalid c%0d", k), 32'(bus_a.drvalid_o), 32'(k >= 2 && (k - 2) % 5 != 4));
      nxt();
    end
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    repeat (3) nxt();
    drv_a(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3 wr dgrant", 32'(bus_a.dgrant_o), 1);
    chk("t3 wr we", 32'(bus_a.mem_we_o), 1);
    chk("t3 wr mask", 32'(bus_a.mem_wmask_o), 32'h3);
    chk("t3 wr data", bus_a.mem_wdata_o, 32'hDEAD_BEEF);
    chk("t3 wr addr", bus_a.mem_addr_o, 32'h100);
    nxt();
    drv_a(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3 rd we", 32'(bus_a.mem_we_o), 0);
    chk("t3 rd mask", 32'(bus_a.mem_wmask_o), 0);
    nxt();
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t3 no wr resp", 32'(bus_a.drvalid_o), 0);
    nxt();
    @(negedge clk);
    chk("t3 rd drvalid", 32'(bus_a.drvalid_o), 1);
    chk("t3 rd drdata", bus_a.drdata_o, 32'hA5A5_BEEF);
    chk("t3 rd irvalid", 32'(bus_a.irvalid_o), 0);
    nxt();
    @(negedge clk);
    chk("t3 after drvalid", 32'(bus_a.drvalid_o), 0);
    nxt();
    drv_a(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t6 dgrant c%0d", k), 32'(bus_a.dgrant_o), 1);
      chk($sformatf("t6 igrant c%0d", k), 32'(bus_a.igrant_o), 0);
      chk($sformatf("t6 streak c%0d", k), 32'(u_a.r_streak), 0);
      nxt();
    end
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    repeat (3) nxt();
    drv_a(1'b1, 32'h8, 1'b1, 32'hC, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5 c0 dgrant", 32'(bus_a.dgrant_o), 1);
    nxt();
    @(negedge clk);
    chk("t5 c1 dgrant", 32'(bus_a.dgrant_o), 1);
    chk("t5 c1 streak", 32'(u_a.r_streak), 1);
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5 rst igrant", 32'(bus_a.igrant_o), 0);
    chk("t5 rst dgrant", 32'(bus_a.dgrant_o), 0);
    chk("t5 rst drvalid", 32'(bus_a.drvalid_o), 0);
    chk("t5 rst drdata", bus_a.drdata_o, 0);
    chk("t5 rst irdata", bus_a.irdata_o, 0);
    chk("t5 rst streak", 32'(u_a.r_streak), 0);
    nxt();
    @(negedge clk);
    chk("t5 rst2 drvalid", 32'(bus_a.drvalid_o), 0);
    chk("t5 rst2 irvalid", 32'(bus_a.irvalid_o), 0);
    nxt();
    rst_n = 1'b1;
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("t5 post drvalid c%0d", k), 32'(bus_a.drvalid_o), 0);
      chk($sformatf("t5 post irvalid c%0d", k), 32'(bus_a.irvalid_o), 0);
      chk($sformatf("t5 post streak c%0d", k), 32'(u_a.r_streak), 0);
      nxt();
    end
    drv_a(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5 new igrant", 32'(bus_a.igrant_o), 1);
    nxt();
    drv_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5 new early", 32'(bus_a.irvalid_o), 0);
    nxt();
    @(negedge clk);
    chk("t5 new irvalid", 32'(bus_a.irvalid_o), 1);
    chk("t5 new irdata", bus_a.irdata_o, 32'hA5A5_0002);
    chk("t5 new drvalid", 32'(bus_a.drvalid_o), 0);
    nxt();
    for (int k = 0; k < 9; k++) begin
      bus_b.ireq_i  = t4_ir[k];
      bus_b.iaddr_i = t4_ad[k];
      bus_b.dreq_i  = t4_dr[k];
      bus_b.daddr_i = t4_ad[k];
      @(negedge clk);
      chk($sformatf("t4 igrant c%0d", k), 32'(bus_b.igrant_o), 32'(t4_ir[k]));
      chk($sformatf("t4 dgrant c%0d", k), 32'(bus_b.dgrant_o), 32'(t4_dr[k]));
      chk($sformatf("t4 irvalid c%0d", k), 32'(bus_b.irvalid_o), 32'(t4_irv[k]));
      chk($sformatf("t4 drvalid c%0d", k), 32'(bus_b.drvalid_o), 32'(t4_drv[k]));
      if (t4_irv[k]) chk($sformatf("t4 irdata c%0d", k), bus_b.irdata_o, t4_rd[k]);
      if (t4_drv[k]) chk($sformatf("t4 drdata c%0d", k), bus_b.drdata_o, t4_rd[k]);
      nxt();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
